event_cmd_sequencer: RTL

EVENT_CMD_SEQUENCER -- requirements
Module: event_cmd_sequencer

---
 rtl/event_cmd_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/event_cmd_sequencer.sv
// event_cmd_sequencer: queues game events as pending requests and issues them one at a time as flag/trig commands.
module event_cmd_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int GAP = 2
) (
  input  logic       clk_1mhz,
  input  logic       rst_n,
  input  logic       hit,
  input  logic       miss,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [2:0] state,
  input  logic [1:0] stage,
  input  logic [1:0] lives,
  input  logic [6:0] timer,
  input  logic       timer_running,
  input  logic       done,
  output logic [3:0] flag,
  output logic       trig,
  output logic       busy,
  output logic       drop_err
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} fsm_t;
  fsm_t fsm;
  logic [8:0] pend, ev, clr, clr_g;
  logic [2:0] score_cnt, score_nx;
  logic [WW-1:0] wcnt;
  logic [GW-1:0] gcnt;
  logic [6:0] prev_timer;
  logic [3:0] code;
  logic in_play, fall, ev_score, req, go, dec, flush, dec_g, flush_g, drop, timeout;
  assign in_play = state == 3'd1;
  assign fall = in_play && timer == 7'd0 && prev_timer != 7'd0;
  assign ev_score = hit && in_play;
  assign ev = {miss && in_play && lives == 2'd1,
               fall && stage == 2'd3,
               fall && stage != 2'd3,
               miss && in_play,
               pause_btn && in_play && timer_running,
               pause_btn && in_play && !timer_running,
               start_btn && (state == 3'd3 || state == 3'd5),
               start_btn && state == 3'd4,
               start_btn && state == 3'd0};
  assign req = |pend || score_cnt != 3'd0;
  always_comb begin
    code = 4'b0000;
    clr = '0;
    dec = 1'b0;
    flush = 1'b0;
    if (pend[8]) begin code = 4'b1101; clr = '1; flush = 1'b1; end
    else if (pend[7]) begin code = 4'b1110; clr[7] = 1'b1; end
    else if (pend[6]) begin code = 4'b1100; clr[6] = 1'b1; end
    else if (pend[5]) begin code = 4'b0010; clr[5] = 1'b1; end
    else if (score_cnt != 3'd0) begin code = 4'b0001; dec = 1'b1; end
    else if (pend[4]) begin code = 4'b0100; clr[4] = 1'b1; end
    else if (pend[3]) begin code = 4'b0101; clr[3] = 1'b1; end
    else if (pend[2]) begin code = 4'b1111; clr[2:0] = 3'b111; flush = 1'b1; end
    else if (pend[1]) begin code = 4'b1000; clr[1] = 1'b1; end
    else if (pend[0]) begin code = 4'b1010; clr[0] = 1'b1; end
  end
  assign go = fsm == S_IDLE && req;
  assign clr_g = go ? clr : '0;
  assign dec_g = go && dec;
  assign flush_g = go && flush;
  assign score_nx = flush_g ? {2'b00, ev_score} :
                    (ev_score && !dec_g && score_cnt != 3'd7) ? score_cnt + 3'd1 :
                    (!ev_score && dec_g) ? score_cnt - 3'd1 : score_cnt;
  assign drop = |(ev & pend & ~clr_g) || (ev_score && score_cnt == 3'd7 && !dec_g && !flush_g);
  assign timeout = fsm == S_WAIT && !done && wcnt == WW'(TIMEOUT - 1);
  always_ff @(posedge clk_1mhz) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      flag <= 4'b0000;
      trig <= 1'b0;
      busy <= 1'b0;
      drop_err <= 1'b0;
      pend <= '0;
      score_cnt <= 3'd0;
      wcnt <= '0;
      gcnt <= '0;
      prev_timer <= 7'd0;
    end else begin
      prev_timer <= timer;
      pend <= (pend & ~clr_g) | ev;
      score_cnt <= score_nx;
      if (drop || timeout) drop_err <= 1'b1;
      unique case (fsm)
        S_IDLE: if (go) begin
          flag <= code;
          trig <= 1'b1;
          busy <= 1'b1;
          fsm <= S_ISSUE;
        end
        S_ISSUE: begin
          wcnt <= '0;
          fsm <= S_WAIT;
        end
        S_WAIT: if (done || wcnt == WW'(TIMEOUT - 1)) begin
          trig <= 1'b0;
          gcnt <= '0;
          fsm <= S_GAP;
        end else wcnt <= wcnt + WW'(1);
        S_GAP: if (gcnt == GW'(GAP - 1)) begin
          busy <= 1'b0;
          fsm <= S_IDLE;
        end else gcnt <= gcnt + GW'(1);
      endcase
    end
  end
endmodule
